// File: rtl/ram_stream_reader.sv
// ram_stream_reader: sequential RAM read engine that turns a (base, count) command into a valid/ready word stream.
// Latency: start sampled at edge E0 -> first m_valid after E2; one word per cycle sustained with m_ready high.
// Backpressure: outstanding reads + buffered words capped at 4; issue stalls while full and resumes next cycle.
// Optional feature macro: RAM_STREAM_WRAP_EN (ram_addr wraps from DATA_DEPTH-1 to 0; ranges may cross the end).

// Small generic FIFO: power-of-two depth, registered level, storage cleared on reset.
module ram_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             head_vld,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage, pointers and level; flush empties without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
  assign head_vld = (level != '0);

endmodule

module ram_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 108,
  parameter int DATA_DEPTH = 800,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  count,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam int SUM_W = ((ADDR_WIDTH > CNT_WIDTH) ? ADDR_WIDTH : CNT_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  remaining;
  logic                  tag_vld;
  logic                  tag_last;
  logic [2:0]            fifo_level;
  logic [2:0]            occupancy;
  logic [DATA_WIDTH:0]   head_dat;
  logic [SUM_W-1:0]      cmd_end;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  cmd_legal;
  logic                  start_ok;
  logic                  cmd_go;
  logic                  cmd_zero;
  logic                  cmd_bad;
  logic                  issue;
  logic                  issue_last;
  logic                  flush;
  logic                  pop;
  logic                  last_pop;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort wins in RUN/DRAIN, the final handshake ends DRAIN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_go) state_nxt = RUN;
      RUN:     if (abort) state_nxt = IDLE;
               else if (issue_last) state_nxt = DRAIN;
      DRAIN:   if (abort) state_nxt = IDLE;
               else if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode: command legality, issue gating and handshake terms.
  always_comb begin
    cmd_end = SUM_W'(base_addr) + SUM_W'(count);
    if (SUM_W'(base_addr) >= SUM_W'(DATA_DEPTH)) cmd_legal = 1'b0;
`ifdef RAM_STREAM_WRAP_EN
    else cmd_legal = (SUM_W'(count) <= SUM_W'(DATA_DEPTH));
`else
    else cmd_legal = (cmd_end <= SUM_W'(DATA_DEPTH));
`endif
`ifdef RAM_STREAM_WRAP_EN
    addr_nxt = (SUM_W'(ram_addr) == SUM_W'(DATA_DEPTH - 1)) ? '0 : ram_addr + 1'b1;
`else
    addr_nxt = ram_addr + 1'b1;
`endif
    busy       = (state != IDLE);
    start_ok   = (state == IDLE) && start && !abort;
    cmd_go     = start_ok && cmd_legal && (count != '0);
    cmd_zero   = start_ok && cmd_legal && (count == '0);
    cmd_bad    = start_ok && !cmd_legal;
    flush      = abort && (state != IDLE);
    // Space check uses registered counts only; a pop this cycle frees space next cycle.
    occupancy  = {2'b00, tag_vld} + fifo_level;
    issue      = (state == RUN) && !abort && (occupancy < 3'd4);
    issue_last = issue && (remaining == CNT_WIDTH'(1));
    pop        = m_valid && m_ready;
    last_pop   = (state == DRAIN) && !abort && pop && m_last;
  end

  // Address/counter and the one-deep read tag that tracks the RAM's registered latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      remaining <= '0;
      tag_vld   <= 1'b0;
      tag_last  <= 1'b0;
    end else begin
      if (cmd_go) begin
        ram_addr  <= base_addr;
        remaining <= count;
      end else if (issue) begin
        ram_addr  <= addr_nxt;
        remaining <= remaining - 1'b1;
      end
      tag_vld  <= issue && !flush;
      tag_last <= issue_last;
    end
  end

  // Single-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= cmd_zero || last_pop;
      err  <= cmd_bad;
    end
  end

  // Output buffer; a tag exiting pushes ram_q with its last flag (space is guaranteed by issue gating).
  ram_stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (4)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (tag_vld),
    .push_dat ({tag_last, ram_q}),
    .pop      (pop),
    .head_dat (head_dat),
    .head_vld (m_valid),
    .level    (fifo_level)
  );

  assign m_data = head_dat[DATA_WIDTH-1:0];
  assign m_last = m_valid && head_dat[DATA_WIDTH];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: behavioural RAM plus a queue-based reference of the expected word stream.
// Cycle index 0 is the falling edge where start is driven; outputs are sampled on falling edges.
// Honours RAM_STREAM_WRAP_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_ram_stream_reader;
  localparam int AW = 10, DW = 108, DEPTH = 800, CW = 11;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, m_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] count = '0;
  logic          busy, done, err, m_valid, m_last;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_q, m_data;
  logic [DW-1:0] mem [0:1023];

  int tests = 0, fails = 0;

  // observations from the last collect() run
  logic [DW-1:0] got_dat[$];
  bit            got_last[$];
  int            got_cyc[$];
  logic [DW-1:0] exp_q[$];
  int first_vld, done_cyc, done_cnt, err_cyc, err_cnt, hold_bad, abort_cyc, addr_at15;
  bit vld_after_abort, busy_after_abort, busy_at1;

  always #5 clk = ~clk;

  // RAM with one-cycle registered read
  always @(posedge clk) ram_q <= mem[ram_addr];

  ram_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .abort(abort), .busy(busy), .done(done), .err(err), .ram_addr(ram_addr),
    .ram_q(ram_q), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  function automatic bit legal(int b, int c);
    if (b >= DEPTH) return 1'b0;
`ifdef RAM_STREAM_WRAP_EN
    return c <= DEPTH;
`else
    return (b + c) <= DEPTH;
`endif
  endfunction

  // reference stream: word i of a legal command is mem[(base+i) mod depth]
  function automatic void model(int b, int c);
    exp_q.delete();
    if (legal(b, c))
      for (int i = 0; i < c; i++) exp_q.push_back(mem[(b + i) % DEPTH]);
  endfunction

  // -2: length differs, -1: identical, else first differing index
  function automatic int first_diff();
    if (got_dat.size() != exp_q.size()) return -2;
    for (int i = 0; i < exp_q.size(); i++) if (got_dat[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic bit last_ok();
    for (int i = 0; i < got_last.size(); i++)
      if (got_last[i] != (i == got_last.size() - 1)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit ready_for(int mode, int cyc);
    case (mode)
      0: return 1'b1;
      1: return 1'($urandom_range(0, 1));
      2: return (cyc % 4 == 0) || (cyc % 4 == 3);
      default: return cyc >= 16;
    endcase
  endfunction

  // Issue one command and watch the stream for ncyc cycles (bounded).
  task automatic collect(input int b, input int c, input int mode, input int abort_after, input int ncyc);
    bit pv, pr, pl;
    logic [DW-1:0] pd;
    got_dat.delete(); got_last.delete(); got_cyc.delete();
    first_vld = -1; done_cyc = -1; done_cnt = 0; err_cyc = -1; err_cnt = 0;
    hold_bad = 0; abort_cyc = -1; addr_at15 = -1;
    vld_after_abort = 1'b1; busy_after_abort = 1'b1; busy_at1 = 1'b0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        base_addr = AW'(b); count = CW'(c); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (pv && !pr && !(abort_cyc >= 0 && cyc == abort_cyc + 1))
        if (!m_valid || m_data !== pd || m_last !== pl) hold_bad++;
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (err)  begin err_cnt++;  if (err_cyc < 0)  err_cyc = cyc;  end
      if (m_valid && first_vld < 0) first_vld = cyc;
      if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
        vld_after_abort = m_valid; busy_after_abort = busy;
      end
      if (cyc == 1) busy_at1 = busy;
      if (cyc == 15) addr_at15 = int'(ram_addr);
      abort = (abort_after >= 0 && first_vld >= 0 && cyc == first_vld + abort_after);
      if (abort) abort_cyc = cyc;
      m_ready = ready_for(mode, cyc);
      if (m_valid && m_ready && abort_cyc < 0) begin
        got_dat.push_back(m_data); got_last.push_back(m_last); got_cyc.push_back(cyc);
      end
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
    end
    abort = 1'b0; m_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0)    begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (err !== 1'b0)     begin fails++; $display("FAIL reset_err got %b want 0", err); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", m_valid); end
    tests++; if (m_last !== 1'b0)  begin fails++; $display("FAIL reset_last got %b want 0", m_last); end
    tests++; if (m_data !== '0)    begin fails++; $display("FAIL reset_data got %h want 0", m_data); end
    tests++; if (ram_addr !== '0)  begin fails++; $display("FAIL reset_addr got %0d want 0", ram_addr); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int d;
    model(5, 4);
    collect(5, 4, 0, -1, 14);
    d = first_diff();
    tests++; if (d != -1) begin fails++; $display("FAIL basic_words first bad %0d got %0d words want 4", d, got_dat.size()); end
    tests++; if (first_vld != 3) begin fails++; $display("FAIL basic_latency got cycle %0d want 3", first_vld); end
    for (int i = 0; i < got_cyc.size(); i++) begin
      tests++; if (got_cyc[i] != 3 + i) begin fails++; $display("FAIL basic_beat%0d got cycle %0d want %0d", i, got_cyc[i], 3 + i); end
    end
    tests++; if (!last_ok() || got_last.size() != 4) begin fails++; $display("FAIL basic_last got bad last flags want only on word 3"); end
    tests++; if (done_cyc != 7 || done_cnt != 1) begin fails++; $display("FAIL basic_done got cycle %0d count %0d want cycle 7 count 1", done_cyc, done_cnt); end
    tests++; if (busy_at1 !== 1'b1) begin fails++; $display("FAIL basic_busy got %b want 1", busy_at1); end
    tests++; if (err_cnt != 0) begin fails++; $display("FAIL basic_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_toggle_ready();
    int d;
    model(200, 6);
    collect(200, 6, 2, -1, 40);
    d = first_diff();
    tests++; if (d != -1) begin fails++; $display("FAIL toggle_words first bad %0d got %0d words want 6", d, got_dat.size()); end
    tests++; if (hold_bad != 0) begin fails++; $display("FAIL toggle_hold got %0d violations want 0", hold_bad); end
    tests++; if (!last_ok()) begin fails++; $display("FAIL toggle_last got bad last flags want only final"); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL toggle_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero_count();
    collect(10, 0, 0, -1, 8);
    tests++; if (done_cyc != 1 || done_cnt != 1) begin fails++; $display("FAIL zero_done got cycle %0d count %0d want cycle 1 count 1", done_cyc, done_cnt); end
    tests++; if (first_vld != -1) begin fails++; $display("FAIL zero_valid got valid at %0d want never", first_vld); end
    tests++; if (busy_at1 !== 1'b0) begin fails++; $display("FAIL zero_busy got %b want 0", busy_at1); end
    tests++; if (err_cnt != 0) begin fails++; $display("FAIL zero_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_range_edges();
    int d;
    model(798, 4);
    collect(798, 4, 0, -1, 14);
`ifdef RAM_STREAM_WRAP_EN
    d = first_diff();
    tests++; if (d != -1) begin fails++; $display("FAIL wrap_words first bad %0d got %0d words want 4", d, got_dat.size()); end
    tests++; if (done_cnt != 1 || err_cnt != 0) begin fails++; $display("FAIL wrap_done got done %0d err %0d want 1 0", done_cnt, err_cnt); end
`else
    tests++; if (err_cyc != 1 || err_cnt != 1) begin fails++; $display("FAIL range_err got cycle %0d count %0d want cycle 1 count 1", err_cyc, err_cnt); end
    tests++; if (first_vld != -1 || done_cnt != 0) begin fails++; $display("FAIL range_noread got valid %0d done %0d want -1 0", first_vld, done_cnt); end
`endif
    model(796, 4);
    collect(796, 4, 0, -1, 14);
    d = first_diff();
    tests++; if (d != -1) begin fails++; $display("FAIL top_words first bad %0d got %0d words want 4", d, got_dat.size()); end
    collect(800, 1, 0, -1, 6);
    tests++; if (err_cnt != 1 || first_vld != -1) begin fails++; $display("FAIL base_err got err %0d valid %0d want 1 -1", err_cnt, first_vld); end
    model(0, 800);
    collect(0, 800, 0, -1, 810);
    d = first_diff();
    tests++; if (d != -1) begin fails++; $display("FAIL full_words first bad %0d got %0d words want 800", d, got_dat.size()); end
    tests++; if (done_cyc != 803) begin fails++; $display("FAIL full_done got cycle %0d want 803", done_cyc); end
  endtask

  task automatic test_backpressure();
    int d;
    model(100, 10);
    collect(100, 10, 3, -1, 60);
    tests++; if (addr_at15 != 104) begin fails++; $display("FAIL stall_addr got %0d want 104", addr_at15); end
    d = first_diff();
    tests++; if (d != -1) begin fails++; $display("FAIL stall_words first bad %0d got %0d words want 10", d, got_dat.size()); end
    tests++; if (hold_bad != 0) begin fails++; $display("FAIL stall_hold got %0d violations want 0", hold_bad); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL stall_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_abort();
    int d;
    collect(0, 10, 0, 2, 24);
    tests++; if (abort_cyc != 5) begin fails++; $display("FAIL abort_when got cycle %0d want 5", abort_cyc); end
    tests++; if (vld_after_abort !== 1'b0 || busy_after_abort !== 1'b0) begin fails++; $display("FAIL abort_drop got valid %b busy %b want 0 0", vld_after_abort, busy_after_abort); end
    tests++; if (done_cnt != 0) begin fails++; $display("FAIL abort_nodone got %0d want 0", done_cnt); end
    model(0, 2);
    collect(0, 2, 0, -1, 12);
    d = first_diff();
    tests++; if (d != -1) begin fails++; $display("FAIL abort_next first bad %0d got %0d words want 2", d, got_dat.size()); end
    tests++; if (done_cyc != 5) begin fails++; $display("FAIL abort_next_done got cycle %0d want 5", done_cyc); end
  endtask

  task automatic test_reset_mid();
    int d;
    @(negedge clk);
    base_addr = AW'(50); count = CW'(10); start = 1'b1;
    @(negedge clk);
    start = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if ({busy, done, err, m_valid, m_last} !== 5'b0) begin fails++; $display("FAIL midrst_ctrl got %b want 00000", {busy, done, err, m_valid, m_last}); end
    tests++; if (m_data !== '0 || ram_addr !== '0) begin fails++; $display("FAIL midrst_data got data %h addr %0d want 0 0", m_data, ram_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    model(0, 2);
    collect(0, 2, 0, -1, 12);
    d = first_diff();
    tests++; if (d != -1) begin fails++; $display("FAIL midrst_words first bad %0d got %0d words want 2", d, got_dat.size()); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL midrst_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_random();
    int b, c, d;
    for (int n = 0; n < 30; n++) begin
      c = $urandom_range(0, 20);
      if ($urandom_range(0, 3) == 0) b = DEPTH - c + $urandom_range(0, 2) - 1;
      else b = $urandom_range(0, DEPTH + 15);
      if (b < 0) b = 0;
      model(b, c);
      collect(b, c, 1, -1, c * 8 + 20);
      if (!legal(b, c)) begin
        tests++; if (err_cnt != 1 || done_cnt != 0 || first_vld != -1) begin fails++; $display("FAIL rand_illegal b=%0d c=%0d got err %0d done %0d valid %0d want 1 0 -1", b, c, err_cnt, done_cnt, first_vld); end
      end else begin
        d = first_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL rand_words b=%0d c=%0d first bad %0d got %0d words", b, c, d, got_dat.size()); end
        tests++; if (done_cnt != 1 || err_cnt != 0) begin fails++; $display("FAIL rand_status b=%0d c=%0d got done %0d err %0d want 1 0", b, c, done_cnt, err_cnt); end
        tests++; if (!last_ok() || hold_bad != 0) begin fails++; $display("FAIL rand_stream b=%0d c=%0d got hold errors %0d or bad last want clean", b, c, hold_bad); end
      end
    end
  endtask

  initial begin
    logic [127:0] w;
    for (int i = 0; i < 1024; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      mem[i] = w[DW-1:0];
    end
    test_reset();
    test_basic();
    test_toggle_ready();
    test_zero_count();
    test_range_edges();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
